bsg_mla_csr_ctrl: RTL and testbench

BSG_MLA_CSR_CTRL -- requirements
Module: bsg_mla_csr_ctrl

---
 rtl/bsg_mla_csr_pkg.sv | 17 +
 rtl/bsg_mla_csr_rr_arb.sv | 55 +++++
 rtl/bsg_mla_csr_ctrl.sv | 141 ++++++++++++++
 tb/tb_bsg_mla_csr_ctrl.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/bsg_mla_csr_pkg.sv
// bsg_mla_csr_pkg
//   Shared types and helpers for the MLA CSR mem-side controller.
//   - state_e     : controller FSM states (IDLE / ACCESS / RESP)
//   - safe_clog2  : clog2 that never returns 0, so derived widths stay >= 1
package bsg_mla_csr_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

  function automatic int safe_clog2(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bsg_mla_csr_rr_arb.sv
// bsg_mla_csr_rr_arb
//   Round-robin arbiter. The search for a grant starts at the priority
//   pointer; on advance the pointer moves to the requester just past the
//   one granted, so the last winner becomes lowest priority.
// Ports:
//   clk_i, reset_i : clock, synchronous active-high reset (pointer -> 0)
//   reqs_i         : request vector
//   advance_i      : commit the current grant and move the pointer
//   grant_o        : one-hot grant (combinational)
//   grant_idx_o    : binary index of grant_o
module bsg_mla_csr_rr_arb
  import bsg_mla_csr_pkg::*;
#(
  parameter int num_req_p = 2
) (
  input  logic                                clk_i,
  input  logic                                reset_i,
  input  logic [num_req_p-1:0]                reqs_i,
  input  logic                                advance_i,
  output logic [num_req_p-1:0]                grant_o,
  output logic [safe_clog2(num_req_p)-1:0]    grant_idx_o
);

  localparam int idx_w_lp = safe_clog2(num_req_p);

  logic [idx_w_lp-1:0] ptr_r;
  logic                found;
  int                  idx;

  // Walk the requesters in order ptr, ptr+1, ... and take the first one set.
  always_comb begin
    grant_o     = '0;
    grant_idx_o = '0;
    found       = 1'b0;
    idx         = 0;
    for (int k = 0; k < num_req_p; k++) begin
      idx = (int'(ptr_r) + k) % num_req_p;
      for (int j = 0; j < num_req_p; j++) begin
        if (!found && reqs_i[j] && (j == idx)) begin
          found       = 1'b1;
          grant_o[j]  = 1'b1;
          grant_idx_o = idx_w_lp'(j);
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i)
      ptr_r <= '0;
    else if (advance_i && found)
      ptr_r <= idx_w_lp'((int'(grant_idx_o) + 1) % num_req_p);
  end

endmodule

// File: rtl/bsg_mla_csr_ctrl.sv
// bsg_mla_csr_ctrl
//   Arbitrates several requesters onto the mem-side bus of a bank of CSRs.
//   One access is in flight at a time: accept (IDLE) -> bus cycle (ACCESS)
//   -> response held until consumed (RESP).
// Ports:
//   clk_i, reset_i   : clock, synchronous active-high reset
//   req_v/w/addr/data_i, req_yumi_o : per-requester request + one-hot accept
//   resp_v_o, resp_data_o, resp_err_o, resp_ready_i : response channel
//   csr_mem_data_o, csr_mem_wen_o, csr_mem_data_i   : CSR mem-side bus
// Configuration:
//   BSG_MLA_CSR_CTRL_ADDR_ERR_EN : when defined, resp_err_o flags
//   out-of-range accesses; otherwise resp_err_o is tied to 0.
//
// state  | meaning
// IDLE   | waiting for a request; grant + accept happen here
// ACCESS | one bus cycle: write pulse or readback capture
// RESP   | response presented until resp_ready_i
module bsg_mla_csr_ctrl
  import bsg_mla_csr_pkg::*;
#(
  parameter int num_csrs_p   = 8,
  parameter int mem_width_p  = 32,
  parameter int num_req_p    = 2,
  parameter int addr_width_p = safe_clog2(num_csrs_p) + 1
) (
  input  logic                                   clk_i,
  input  logic                                   reset_i,
  input  logic [num_req_p-1:0]                   req_v_i,
  input  logic [num_req_p-1:0]                   req_w_i,
  input  logic [num_req_p-1:0][addr_width_p-1:0] req_addr_i,
  input  logic [num_req_p-1:0][mem_width_p-1:0]  req_data_i,
  output logic [num_req_p-1:0]                   req_yumi_o,
  output logic [num_req_p-1:0]                   resp_v_o,
  output logic [mem_width_p-1:0]                 resp_data_o,
  output logic                                   resp_err_o,
  input  logic                                   resp_ready_i,
  output logic [mem_width_p-1:0]                 csr_mem_data_o,
  output logic [num_csrs_p-1:0]                  csr_mem_wen_o,
  input  logic [num_csrs_p-1:0][mem_width_p-1:0] csr_mem_data_i
);

  localparam int req_idx_w_lp = safe_clog2(num_req_p);

  state_e                    state_r;
  logic [num_req_p-1:0]      grant;
  logic [req_idx_w_lp-1:0]   grant_idx;
  logic [num_req_p-1:0]      grant_r;
  logic                      w_r;
  logic [addr_width_p-1:0]   addr_r;
  logic [mem_width_p-1:0]    data_r;
  logic [mem_width_p-1:0]    resp_data_r;
`ifdef BSG_MLA_CSR_CTRL_ADDR_ERR_EN
  logic                      err_r;
`endif

  logic [num_csrs_p-1:0]     addr_dec;
  logic [mem_width_p-1:0]    rd_data;
  logic                      in_range;
  logic                      accept;
  logic                      live;

  // Outputs are forced quiet while reset_i is high, so a reset that lands
  // mid-access cannot leak a write pulse or a response in that cycle.
  assign live   = !reset_i;
  assign accept = live && (state_r == IDLE) && (|req_v_i);

  bsg_mla_csr_rr_arb #(
    .num_req_p (num_req_p)
  ) rr_arb (
    .clk_i       (clk_i),
    .reset_i     (reset_i),
    .reqs_i      (req_v_i),
    .advance_i   (accept),
    .grant_o     (grant),
    .grant_idx_o (grant_idx)
  );

  // Address decode doubles as the range check: no match means out of range.
  always_comb begin
    addr_dec = '0;
    rd_data  = '0;
    for (int i = 0; i < num_csrs_p; i++) begin
      if (addr_r == addr_width_p'(i)) begin
        addr_dec[i] = 1'b1;
        rd_data     = csr_mem_data_i[i];
      end
    end
  end

  assign in_range = |addr_dec;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_r     <= IDLE;
      grant_r     <= '0;
      w_r         <= 1'b0;
      addr_r      <= '0;
      data_r      <= '0;
      resp_data_r <= '0;
`ifdef BSG_MLA_CSR_CTRL_ADDR_ERR_EN
      err_r       <= 1'b0;
`endif
    end else begin
      case (state_r)
        IDLE: begin
          if (accept) begin
            grant_r <= grant;
            w_r     <= req_w_i[grant_idx];
            addr_r  <= req_addr_i[grant_idx];
            data_r  <= req_data_i[grant_idx];
            state_r <= ACCESS;
          end
        end
        ACCESS: begin
          resp_data_r <= (!w_r && in_range) ? rd_data : '0;
`ifdef BSG_MLA_CSR_CTRL_ADDR_ERR_EN
          err_r       <= !in_range;
`endif
          state_r     <= RESP;
        end
        RESP: begin
          if (resp_ready_i)
            state_r <= IDLE;
        end
        default: state_r <= IDLE;
      endcase
    end
  end

  assign req_yumi_o     = accept ? grant : '0;
  assign csr_mem_wen_o  = (live && (state_r == ACCESS) && w_r) ? addr_dec : '0;
  assign csr_mem_data_o = data_r;
  assign resp_v_o       = (live && (state_r == RESP)) ? grant_r : '0;
  assign resp_data_o    = (live && (state_r == RESP)) ? resp_data_r : '0;
`ifdef BSG_MLA_CSR_CTRL_ADDR_ERR_EN
  assign resp_err_o     = live && (state_r == RESP) && err_r;
`else
  assign resp_err_o     = 1'b0;
`endif

endmodule

// File: tb/tb_bsg_mla_csr_ctrl.sv
// tb_bsg_mla_csr_ctrl
//   Directed bench for bsg_mla_csr_ctrl with a behavioural CSR bank hung on
//   the mem-side bus. Expected values are hand-computed per step.
module tb_bsg_mla_csr_ctrl;

  localparam int NC = 8;
  localparam int MW = 32;
  localparam int NR = 2;
  localparam int AW = 4;
`ifdef BSG_MLA_CSR_CTRL_ADDR_ERR_EN
  localparam logic ERR_EXP = 1'b1;
`else
  localparam logic ERR_EXP = 1'b0;
`endif

  logic                   clk = 1'b0;
  logic                   reset;
  logic [NR-1:0]          req_v;
  logic [NR-1:0]          req_w;
  logic [NR-1:0][AW-1:0]  req_addr;
  logic [NR-1:0][MW-1:0]  req_data;
  logic [NR-1:0]          yumi;
  logic [NR-1:0]          resp_v;
  logic [MW-1:0]          resp_data;
  logic                   resp_err;
  logic                   resp_ready;
  logic [MW-1:0]          mem_data;
  logic [NC-1:0]          wen;
  logic [NC-1:0][MW-1:0]  csr_q;
  logic                   csr_init;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  // Behavioural CSR bank: loads 0x1000_000i at init, then takes mem-side writes.
  always @(posedge clk) begin
    for (int i = 0; i < NC; i++) begin
      if (csr_init)
        csr_q[i] <= 32'h1000_0000 | MW'(i);
      else if (wen[i])
        csr_q[i] <= mem_data;
    end
  end

  bsg_mla_csr_ctrl #(
    .num_csrs_p  (NC),
    .mem_width_p (MW),
    .num_req_p   (NR)
  ) dut (
    .clk_i          (clk),
    .reset_i        (reset),
    .req_v_i        (req_v),
    .req_w_i        (req_w),
    .req_addr_i     (req_addr),
    .req_data_i     (req_data),
    .req_yumi_o     (yumi),
    .resp_v_o       (resp_v),
    .resp_data_o    (resp_data),
    .resp_err_o     (resp_err),
    .resp_ready_i   (resp_ready),
    .csr_mem_data_o (mem_data),
    .csr_mem_wen_o  (wen),
    .csr_mem_data_i (csr_q)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Entered at posedge+1 in IDLE with the request inputs already set;
  // leaves at posedge+1 back in IDLE (resp_ready assumed high).
  task automatic access(input string tag, input logic [NR-1:0] exp_g,
                        input logic [NC-1:0] exp_wen, input logic [MW-1:0] exp_wdata,
                        input logic [MW-1:0] exp_rdata, input logic exp_err);
    #1;
    chk({tag, ":yumi"}, yumi, exp_g);
    chk({tag, ":idle_wen"}, wen, 0);
    tick();
    chk({tag, ":wen"}, wen, exp_wen);
    chk({tag, ":wdata"}, mem_data, exp_wdata);
    chk({tag, ":acc_yumi"}, yumi, 0);
    chk({tag, ":acc_resp_v"}, resp_v, 0);
    tick();
    chk({tag, ":resp_v"}, resp_v, exp_g);
    chk({tag, ":resp_data"}, resp_data, exp_rdata);
    chk({tag, ":resp_err"}, resp_err, exp_err);
    chk({tag, ":resp_yumi"}, yumi, 0);
    chk({tag, ":resp_wen"}, wen, 0);
    tick();
  endtask

  initial begin
    reset      = 1'b1;
    csr_init   = 1'b1;
    req_v      = '0;
    req_w      = '0;
    req_addr   = '0;
    req_data   = '0;
    resp_ready = 1'b1;
    tick();
    tick();

    // Reset: outputs quiet even with requests pending.
    req_v = 2'b11;
    #1;
    chk("rst:yumi", yumi, 0);
    chk("rst:resp_v", resp_v, 0);
    chk("rst:wen", wen, 0);
    chk("rst:resp_data", resp_data, 0);
    chk("rst:resp_err", resp_err, 0);
    req_v    = '0;
    csr_init = 1'b0;
    reset    = 1'b0;
    tick();
    chk("idle:yumi", yumi, 0);
    chk("idle:resp_v", resp_v, 0);

    // Write addr 3 then read it back (lone requester served back-to-back).
    req_v = 2'b01; req_w[0] = 1'b1; req_addr[0] = 4'd3; req_data[0] = 32'hDEAD_BEEF;
    access("wr3", 2'b01, 8'b0000_1000, 32'hDEAD_BEEF, 32'h0, 1'b0);
    req_w[0] = 1'b0; req_data[0] = 32'h0;
    access("rd3", 2'b01, 8'b0, 32'h0, 32'hDEAD_BEEF, 1'b0);
    req_v = '0;
    tick();
    chk("noreq:yumi", yumi, 0);
    chk("noreq:resp_v", resp_v, 0);

    // Response stall: ready low 5 cycles while req0 waits.
    req_v = 2'b10; req_w[1] = 1'b0; req_addr[1] = 4'd5; req_data[1] = 32'h0;
    #1;
    chk("stall:yumi", yumi, 2'b10);
    tick();
    resp_ready = 1'b0;
    req_v      = 2'b11;
    tick();
    for (int i = 0; i < 5; i++) begin
      chk("stall:resp_v", resp_v, 2'b10);
      chk("stall:resp_data", resp_data, 32'h1000_0005);
      chk("stall:yumi_hold", yumi, 0);
      tick();
    end
    resp_ready = 1'b1;
    #1;
    chk("stall:ready_resp_v", resp_v, 2'b10);
    chk("stall:ready_yumi", yumi, 0);
    tick();
    chk("stall:idle_yumi", yumi, 2'b01);
    chk("stall:idle_resp_v", resp_v, 0);
    access("rd3b", 2'b01, 8'b0, 32'h0, 32'hDEAD_BEEF, 1'b0);
    req_v = '0;

    // Out-of-range write and read at addr 9.
    req_v = 2'b01; req_w[0] = 1'b1; req_addr[0] = 4'd9; req_data[0] = 32'h1234_5678;
    access("wr9", 2'b01, 8'b0, 32'h1234_5678, 32'h0, ERR_EXP);
    req_w[0] = 1'b0; req_data[0] = 32'h0;
    access("rd9", 2'b01, 8'b0, 32'h0, 32'h0, ERR_EXP);
    req_v = '0;

    // Reset while in ACCESS of a write to addr 2 (pointer currently at 1).
    req_v = 2'b01; req_w[0] = 1'b1; req_addr[0] = 4'd2; req_data[0] = 32'hCAFE_F00D;
    #1;
    chk("rstacc:yumi", yumi, 2'b01);
    tick();
    reset = 1'b1;
    req_v = '0;
    #1;
    chk("rstacc:wen", wen, 0);
    chk("rstacc:resp_v", resp_v, 0);
    tick();
    chk("rstacc:wen2", wen, 0);
    chk("rstacc:resp_v2", resp_v, 0);
    chk("rstacc:resp_data", resp_data, 0);
    reset = 1'b0;
    tick();
    chk("rstacc:post_resp_v", resp_v, 0);
    chk("rstacc:post_wen", wen, 0);
    tick();
    chk("rstacc:post_resp_v2", resp_v, 0);

    // Both requesters held valid: grants 0,1,0,1; addr 2 still at init value.
    req_v = 2'b11; req_w = 2'b00;
    req_addr[0] = 4'd3; req_addr[1] = 4'd2;
    req_data[0] = 32'h0; req_data[1] = 32'h0;
    access("rr0", 2'b01, 8'b0, 32'h0, 32'hDEAD_BEEF, 1'b0);
    access("rr1", 2'b10, 8'b0, 32'h0, 32'h1000_0002, 1'b0);
    access("rr2", 2'b01, 8'b0, 32'h0, 32'hDEAD_BEEF, 1'b0);
    access("rr3", 2'b10, 8'b0, 32'h0, 32'h1000_0002, 1'b0);
    req_v = '0;
    tick();
    chk("end:yumi", yumi, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
